// File: rtl/alarm_ring_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// alarm_ring_ctrl
//
// Decides when the alarm fires and runs the ring / snooze / stop state
// machine.  While ringing it drives a gated square-wave buzzer (1 s beep,
// 1 s silence).  Sits directly downstream of the time counter.
//
// Ports:
//   CLK           system clock (100 kHz)
//   RESETN        synchronous, active-low reset
//   CUR_TIME      current time  {HOUR[16:12], MIN[11:6], SEC[5:0]}, 24 h
//   ALARM_TIME    programmed alarm time, same format
//   ALARM_EN      alarm armed (level)
//   SETTING_BUSY  time/alarm setting in progress; masks triggers
//   STOP_BTN      debounced stop button, active-high level
//   SNOOZE_BTN    debounced snooze button, active-high level
//   BUZZER        tone output
//   RINGING       FSM is in RINGING
//   SNOOZED       FSM is in SNOOZE
//   SNOOZE_CNT    snoozes used in the current alarm event
//   SNOOZE_TIME   pending snooze target; 0 when not snoozed
// -----------------------------------------------------------------------------
module alarm_ring_ctrl #(
  parameter int TONE_DIV         = 25,
  parameter int RING_TIMEOUT_SEC = 60,
  parameter int SNOOZE_MIN       = 5,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [16:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        SETTING_BUSY,
  input  logic        STOP_BTN,
  input  logic        SNOOZE_BTN,
  output logic        BUZZER,
  output logic        RINGING,
  output logic        SNOOZED,
  output logic [1:0]  SNOOZE_CNT,
  output logic [16:0] SNOOZE_TIME
);

  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [6:0]        RING_LAST = 7'(RING_TIMEOUT_SEC - 1);
  localparam logic [1:0]        MAX_CNT   = 2'(MAX_SNOOZE);
  localparam logic [6:0]        SNZ_ADD   = 7'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [5:0]          prev_sec_reg;
  logic                sec_valid_reg;
  logic [6:0]          ring_sec_reg, ring_sec_next;
  logic [1:0]          snooze_cnt_reg, snooze_cnt_next;
  logic [16:0]         snooze_time_reg, snooze_time_next;
  logic [TONE_W-1:0]   tone_cnt_reg, tone_cnt_next;
  logic                buzzer_reg, buzzer_next;

  // ---------------------------------------------------------------------------
  // Button rising-edge detectors: index 0 = STOP, index 1 = SNOOZE.
  // A held button produces exactly one rise.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_in;
  logic [1:0] btn_q_reg;
  logic [1:0] btn_rise;

  assign btn_in = {SNOOZE_BTN, STOP_BTN};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      always_ff @(posedge CLK) begin
        if (!RESETN) begin
          btn_q_reg[gi] <= 1'b0;
        end else begin
          btn_q_reg[gi] <= btn_in[gi];
        end
      end
      assign btn_rise[gi] = btn_in[gi] & ~btn_q_reg[gi];
    end
  endgenerate

  logic stop_rise;
  logic snooze_rise;
  assign stop_rise   = btn_rise[0];
  assign snooze_rise = btn_rise[1];

  // ---------------------------------------------------------------------------
  // Second strobe and time matches.  sec_valid stays low for the first cycle
  // after reset so a CUR_TIME that already equals ALARM_TIME cannot fire.
  // ---------------------------------------------------------------------------
  logic new_sec;
  logic alarm_hit;
  logic snz_hit;

  assign new_sec   = sec_valid_reg & (CUR_TIME[5:0] != prev_sec_reg);
  assign alarm_hit = new_sec & (CUR_TIME == ALARM_TIME);
  assign snz_hit   = new_sec & (CUR_TIME == snooze_time_reg);

  // ---------------------------------------------------------------------------
  // Snooze target: CUR_TIME + SNOOZE_MIN minutes, wrapping minutes into the
  // hour and the hour past midnight.  Seconds are carried over unchanged.
  // ---------------------------------------------------------------------------
  logic [6:0]  min_sum;
  logic [6:0]  snz_min;
  logic [5:0]  snz_hour;
  logic [16:0] snz_target;

  assign min_sum = {1'b0, CUR_TIME[11:6]} + SNZ_ADD;

  always_comb begin
    snz_min  = min_sum;
    snz_hour = {1'b0, CUR_TIME[16:12]};
    if (min_sum >= 7'd60) begin
      snz_min  = min_sum - 7'd60;
      snz_hour = {1'b0, CUR_TIME[16:12]} + 6'd1;
    end
    if (snz_hour >= 6'd24) begin
      snz_hour = 6'd0;
    end
    snz_target = {snz_hour[4:0], snz_min[5:0], CUR_TIME[5:0]};
  end

  // ---------------------------------------------------------------------------
  // Ring / snooze / stop FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    snooze_cnt_next  = snooze_cnt_reg;
    snooze_time_next = snooze_time_reg;
    ring_sec_next    = ring_sec_reg;

    // Seconds spent ringing, saturating so it can never wrap back to 0.
    if ((state_reg == ST_RINGING) && new_sec && (ring_sec_reg != 7'h7F)) begin
      ring_sec_next = ring_sec_reg + 7'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (ALARM_EN && !SETTING_BUSY && alarm_hit) begin
          state_next      = ST_RINGING;
          ring_sec_next   = 7'd0;
          snooze_cnt_next = 2'd0;
        end
      end

      ST_RINGING: begin
        // Stop conditions take priority, so STOP beats a simultaneous SNOOZE.
        if (stop_rise || !ALARM_EN || (new_sec && (ring_sec_reg == RING_LAST))) begin
          state_next       = ST_IDLE;
          snooze_cnt_next  = 2'd0;
          snooze_time_next = 17'd0;
        end else if (snooze_rise && (snooze_cnt_reg < MAX_CNT)) begin
          state_next       = ST_SNOOZE;
          snooze_cnt_next  = snooze_cnt_reg + 2'd1;
          snooze_time_next = snz_target;
        end
      end

      ST_SNOOZE: begin
        if (stop_rise || !ALARM_EN) begin
          state_next       = ST_IDLE;
          snooze_cnt_next  = 2'd0;
          snooze_time_next = 17'd0;
        end else if (snz_hit && !SETTING_BUSY && ALARM_EN) begin
          state_next       = ST_RINGING;
          ring_sec_next    = 7'd0;
          snooze_time_next = 17'd0;
        end
      end

      default: begin
        state_next       = ST_IDLE;
        snooze_cnt_next  = 2'd0;
        snooze_time_next = 17'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Buzzer: square wave only during even ring seconds of RINGING; otherwise
  // the divider is held at 0 and the pin is low.
  // ---------------------------------------------------------------------------
  logic tone_active;
  assign tone_active = (state_reg == ST_RINGING) & ~ring_sec_reg[0];

  always_comb begin
    tone_cnt_next = '0;
    buzzer_next   = 1'b0;
    if (tone_active) begin
      if (tone_cnt_reg == TONE_LAST) begin
        tone_cnt_next = '0;
        buzzer_next   = ~buzzer_reg;
      end else begin
        tone_cnt_next = tone_cnt_reg + 1'b1;
        buzzer_next   = buzzer_reg;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_reg       <= ST_IDLE;
      prev_sec_reg    <= 6'd0;
      sec_valid_reg   <= 1'b0;
      ring_sec_reg    <= 7'd0;
      snooze_cnt_reg  <= 2'd0;
      snooze_time_reg <= 17'd0;
      tone_cnt_reg    <= '0;
      buzzer_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      prev_sec_reg    <= CUR_TIME[5:0];
      sec_valid_reg   <= 1'b1;
      ring_sec_reg    <= ring_sec_next;
      snooze_cnt_reg  <= snooze_cnt_next;
      snooze_time_reg <= snooze_time_next;
      tone_cnt_reg    <= tone_cnt_next;
      buzzer_reg      <= buzzer_next;
    end
  end

  assign BUZZER      = buzzer_reg;
  assign RINGING     = (state_reg == ST_RINGING);
  assign SNOOZED     = (state_reg == ST_SNOOZE);
  assign SNOOZE_CNT  = snooze_cnt_reg;
  assign SNOOZE_TIME = snooze_time_reg;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_alarm_ring_ctrl
//
// Self-checking bench for alarm_ring_ctrl.  A behavioural model keeps time as
// seconds-of-day and the alarm status as plain integers; the snooze target is
// simply (now + 300 s) mod 86400 and the buzzer level is derived from how many
// consecutive tone-enabled cycles have elapsed.
// -----------------------------------------------------------------------------
module tb_alarm_ring_ctrl;

  localparam int TONE_DIV         = 25;
  localparam int RING_TIMEOUT_SEC = 60;
  localparam int SNOOZE_MIN       = 5;
  localparam int MAX_SNOOZE       = 3;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [16:0] CUR_TIME;
  logic [16:0] ALARM_TIME;
  logic        ALARM_EN;
  logic        SETTING_BUSY;
  logic        STOP_BTN;
  logic        SNOOZE_BTN;
  logic        BUZZER;
  logic        RINGING;
  logic        SNOOZED;
  logic [1:0]  SNOOZE_CNT;
  logic [16:0] SNOOZE_TIME;

  int checks   = 0;
  int failures = 0;

  alarm_ring_ctrl #(
    .TONE_DIV         (TONE_DIV),
    .RING_TIMEOUT_SEC (RING_TIMEOUT_SEC),
    .SNOOZE_MIN       (SNOOZE_MIN),
    .MAX_SNOOZE       (MAX_SNOOZE)
  ) dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .CUR_TIME     (CUR_TIME),
    .ALARM_TIME   (ALARM_TIME),
    .ALARM_EN     (ALARM_EN),
    .SETTING_BUSY (SETTING_BUSY),
    .STOP_BTN     (STOP_BTN),
    .SNOOZE_BTN   (SNOOZE_BTN),
    .BUZZER       (BUZZER),
    .RINGING      (RINGING),
    .SNOOZED      (SNOOZED),
    .SNOOZE_CNT   (SNOOZE_CNT),
    .SNOOZE_TIME  (SNOOZE_TIME)
  );

  always #5 CLK = ~CLK;

  logic [21:0] dut_vec;
  assign dut_vec = {BUZZER, RINGING, SNOOZED, SNOOZE_CNT, SNOOZE_TIME};

  // ---------------------------------------------------------------- time utils
  function automatic logic [16:0] hms(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    hh = 5'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  function automatic logic [16:0] from_secs(input int t);
    int tt;
    tt = ((t % 86400) + 86400) % 86400;
    return hms(tt / 3600, (tt / 60) % 60, tt % 60);
  endfunction

  function automatic int to_secs(input logic [16:0] t);
    return int'(t[16:12]) * 3600 + int'(t[11:6]) * 60 + int'(t[5:0]);
  endfunction

  // ---------------------------------------------------------- reference model
  // m_mode: 0 = idle, 1 = ringing, 2 = snoozed
  int m_mode     = 0;
  int m_ring_sec = 0;
  int m_cnt      = 0;
  int m_target   = 0;
  int m_tone_n   = 0;
  bit m_buzz     = 0;
  bit m_valid    = 0;
  int m_prev_sec = 0;
  bit m_stop_q   = 0;
  bit m_snz_q    = 0;

  task automatic model_step();
    int cur;
    bit new_sec, stop_r, snz_r, hit_a, hit_s, timeout;
    if (!RESETN) begin
      m_mode = 0; m_ring_sec = 0; m_cnt = 0; m_target = 0;
      m_tone_n = 0; m_buzz = 0; m_valid = 0; m_prev_sec = 0;
      m_stop_q = 0; m_snz_q = 0;
      return;
    end
    cur     = to_secs(CUR_TIME);
    new_sec = m_valid && (int'(CUR_TIME[5:0]) != m_prev_sec);
    stop_r  = STOP_BTN && !m_stop_q;
    snz_r   = SNOOZE_BTN && !m_snz_q;
    hit_a   = new_sec && (CUR_TIME == ALARM_TIME);
    hit_s   = new_sec && (cur == m_target);
    timeout = new_sec && (m_ring_sec == RING_TIMEOUT_SEC - 1);

    // Tone: level flips after every TONE_DIV enabled cycles.
    if (m_mode == 1 && (m_ring_sec % 2) == 0) begin
      m_tone_n++;
      m_buzz = ((m_tone_n / TONE_DIV) % 2) == 1;
    end else begin
      m_tone_n = 0;
      m_buzz   = 0;
    end

    case (m_mode)
      0: if (ALARM_EN && !SETTING_BUSY && hit_a) begin
           m_mode = 1; m_ring_sec = 0; m_cnt = 0;
         end
      1: if (stop_r || !ALARM_EN || timeout) begin
           m_mode = 0; m_cnt = 0;
         end else if (snz_r && m_cnt < MAX_SNOOZE) begin
           m_mode = 2; m_cnt++;
           m_target = (cur + SNOOZE_MIN * 60) % 86400;
         end else if (new_sec && m_ring_sec < 127) begin
           m_ring_sec++;
         end
      default: if (stop_r || !ALARM_EN) begin
           m_mode = 0; m_cnt = 0;
         end else if (hit_s && !SETTING_BUSY && ALARM_EN) begin
           m_mode = 1; m_ring_sec = 0;
         end
    endcase

    m_valid    = 1;
    m_prev_sec = int'(CUR_TIME[5:0]);
    m_stop_q   = STOP_BTN;
    m_snz_q    = SNOOZE_BTN;
  endtask

  function automatic logic [21:0] model_vec();
    logic        r, s;
    logic [1:0]  c;
    logic [16:0] st;
    r  = (m_mode == 1);
    s  = (m_mode == 2);
    c  = 2'(m_cnt);
    st = (m_mode == 2) ? from_secs(m_target) : 17'd0;
    return {m_buzz, r, s, c, st};
  endfunction

  // -------------------------------------------------------------- stimulus aids
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      model_step();
      #1;
    end
  endtask

  // Step CUR_TIME onto the alarm second so the controller starts ringing.
  task automatic start_ring(input int h, input int m, input int s);
    ALARM_TIME = hms(h, m, s);
    CUR_TIME   = from_secs(to_secs(hms(h, m, s)) - 1);
    tick(2);
    CUR_TIME   = hms(h, m, s);
    tick(1);
  endtask

  // ---------------------------------------------------------------------- tests
  task automatic test_reset();
    RESETN = 0; CUR_TIME = hms(7, 30, 0); ALARM_TIME = hms(7, 30, 0);
    ALARM_EN = 1; SETTING_BUSY = 0; STOP_BTN = 0; SNOOZE_BTN = 0;
    tick(3);
    checks++;
    if (dut_vec !== 22'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", dut_vec, 22'd0);
    end
    RESETN = 1;
    tick(5);
    checks++;
    if (RINGING !== 1'b0) begin
      failures++; $display("FAIL reset_no_ring: got RINGING=%b expected 0", RINGING);
    end
    checks++;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL reset_model: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_ring_stop();
    logic prev;
    int   toggles;
    start_ring(7, 30, 0);
    checks++;
    if (RINGING !== 1'b1) begin
      failures++; $display("FAIL ring_start: got RINGING=%b expected 1", RINGING);
    end
    prev = BUZZER; toggles = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ring_tone_model cyc %0d: got %h expected %h", i, dut_vec, model_vec());
      end
      if (BUZZER !== prev) toggles++;
      prev = BUZZER;
    end
    checks++;
    if (toggles !== 3 || BUZZER !== 1'b1) begin
      failures++; $display("FAIL ring_tone_toggles: got toggles=%0d BUZZER=%b expected 3 and 1", toggles, BUZZER);
    end
    STOP_BTN = 1; tick(1);
    checks++;
    if (RINGING !== 1'b0) begin
      failures++; $display("FAIL stop_to_idle: got RINGING=%b expected 0", RINGING);
    end
    STOP_BTN = 0; tick(1);
    checks++;
    if (BUZZER !== 1'b0) begin
      failures++; $display("FAIL stop_buzzer_off: got BUZZER=%b expected 0", BUZZER);
    end
  endtask

  task automatic test_snooze();
    start_ring(7, 30, 0);
    CUR_TIME = hms(7, 30, 1); tick(2);
    CUR_TIME = hms(7, 30, 2); tick(1);
    SNOOZE_BTN = 1; tick(1);
    checks++;
    if ({SNOOZED, SNOOZE_CNT, SNOOZE_TIME} !== {1'b1, 2'd1, hms(7, 35, 2)}) begin
      failures++; $display("FAIL snooze_latch: got snz=%b cnt=%0d time=%h expected 1 1 %h",
                           SNOOZED, SNOOZE_CNT, SNOOZE_TIME, hms(7, 35, 2));
    end
    SNOOZE_BTN = 0;
    CUR_TIME = hms(7, 35, 1); tick(2);
    checks++;
    if (dut_vec !== model_vec() || SNOOZED !== 1'b1) begin
      failures++; $display("FAIL snooze_wait: got %h expected %h", dut_vec, model_vec());
    end
    CUR_TIME = hms(7, 35, 2); tick(1);
    checks++;
    if ({RINGING, SNOOZE_CNT, SNOOZE_TIME} !== {1'b1, 2'd1, 17'd0}) begin
      failures++; $display("FAIL snooze_rering: got ring=%b cnt=%0d time=%h expected 1 1 0",
                           RINGING, SNOOZE_CNT, SNOOZE_TIME);
    end
    STOP_BTN = 1; tick(1);
    checks++;
    if (dut_vec !== 22'd0) begin
      failures++; $display("FAIL snooze_stop: got %h expected %h", dut_vec, 22'd0);
    end
    STOP_BTN = 0; tick(1);
  endtask

  task automatic test_snooze_wrap_limit();
    int t;
    start_ring(23, 58, 9);
    CUR_TIME = hms(23, 58, 10); tick(1);
    SNOOZE_BTN = 1; tick(1);
    checks++;
    if (SNOOZE_TIME !== hms(0, 3, 10) || SNOOZE_CNT !== 2'd1) begin
      failures++; $display("FAIL snooze_midnight: got time=%h cnt=%0d expected %h 1",
                           SNOOZE_TIME, SNOOZE_CNT, hms(0, 3, 10));
    end
    SNOOZE_BTN = 0; tick(1);
    for (int k = 1; k <= 3; k++) begin
      t = to_secs(hms(0, 3 + 5 * (k - 1), 10));
      CUR_TIME = from_secs(t - 1); tick(2);
      CUR_TIME = from_secs(t);     tick(1);
      checks++;
      if (RINGING !== 1'b1 || dut_vec !== model_vec()) begin
        failures++; $display("FAIL snooze_rering_%0d: got %h expected %h", k, dut_vec, model_vec());
      end
      SNOOZE_BTN = 1; tick(1);
      checks++;
      if (k < 3) begin
        if ({SNOOZED, SNOOZE_CNT, SNOOZE_TIME} !== {1'b1, 2'(k + 1), hms(0, 3 + 5 * k, 10)}) begin
          failures++; $display("FAIL snooze_count_%0d: got snz=%b cnt=%0d time=%h expected 1 %0d %h",
                               k, SNOOZED, SNOOZE_CNT, SNOOZE_TIME, k + 1, hms(0, 3 + 5 * k, 10));
        end
      end else begin
        if ({RINGING, SNOOZED, SNOOZE_CNT} !== {1'b1, 1'b0, 2'd3}) begin
          failures++; $display("FAIL snooze_limit: got ring=%b snz=%b cnt=%0d expected 1 0 3",
                               RINGING, SNOOZED, SNOOZE_CNT);
        end
      end
      SNOOZE_BTN = 0; tick(1);
    end
    STOP_BTN = 1; tick(1);
    STOP_BTN = 0; tick(1);
  endtask

  task automatic test_timeout();
    int early_stop;
    start_ring(8, 0, 0);
    early_stop = 0;
    for (int s = 1; s < 60; s++) begin
      CUR_TIME = hms(8, 0, s); tick(3);
      checks++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL timeout_model s=%0d: got %h expected %h", s, dut_vec, model_vec());
      end
      if (RINGING !== 1'b1) early_stop++;
    end
    checks++;
    if (early_stop !== 0) begin
      failures++; $display("FAIL timeout_early: got %0d non-ringing seconds expected 0", early_stop);
    end
    CUR_TIME = hms(8, 1, 0); tick(1);
    checks++;
    if (RINGING !== 1'b0 || SNOOZE_CNT !== 2'd0) begin
      failures++; $display("FAIL timeout_stop: got ring=%b cnt=%0d expected 0 0", RINGING, SNOOZE_CNT);
    end
  endtask

  task automatic test_stop_snooze_same();
    start_ring(10, 0, 0);
    SNOOZE_BTN = 1; tick(1);
    SNOOZE_BTN = 0; tick(1);
    CUR_TIME = hms(10, 4, 59); tick(2);
    CUR_TIME = hms(10, 5, 0);  tick(1);
    checks++;
    if (RINGING !== 1'b1 || SNOOZE_CNT !== 2'd1) begin
      failures++; $display("FAIL both_setup: got ring=%b cnt=%0d expected 1 1", RINGING, SNOOZE_CNT);
    end
    STOP_BTN = 1; SNOOZE_BTN = 1; tick(1);
    checks++;
    if ({RINGING, SNOOZED, SNOOZE_CNT} !== 4'b0000) begin
      failures++; $display("FAIL both_stop_wins: got ring=%b snz=%b cnt=%0d expected 0 0 0",
                           RINGING, SNOOZED, SNOOZE_CNT);
    end
    STOP_BTN = 0; SNOOZE_BTN = 0; tick(2);
  endtask

  task automatic test_busy();
    ALARM_TIME = hms(9, 0, 0);
    CUR_TIME = hms(8, 59, 59); tick(2);
    SETTING_BUSY = 1;
    CUR_TIME = hms(9, 0, 0); tick(3);
    checks++;
    if (RINGING !== 1'b0) begin
      failures++; $display("FAIL busy_masks: got RINGING=%b expected 0", RINGING);
    end
    SETTING_BUSY = 0; tick(3);
    checks++;
    if (RINGING !== 1'b0 || dut_vec !== model_vec()) begin
      failures++; $display("FAIL busy_hit_lost: got %h expected %h", dut_vec, model_vec());
    end
    start_ring(9, 10, 0);
    SETTING_BUSY = 1; tick(3);
    checks++;
    if (RINGING !== 1'b1) begin
      failures++; $display("FAIL busy_keeps_ring: got RINGING=%b expected 1", RINGING);
    end
    SETTING_BUSY = 0;
    STOP_BTN = 1; tick(1);
    STOP_BTN = 0; tick(1);
  endtask

  task automatic test_en_drop_snooze();
    start_ring(11, 0, 0);
    SNOOZE_BTN = 1; tick(1);
    SNOOZE_BTN = 0;
    checks++;
    if (SNOOZED !== 1'b1) begin
      failures++; $display("FAIL en_drop_setup: got SNOOZED=%b expected 1", SNOOZED);
    end
    ALARM_EN = 0; tick(1);
    checks++;
    if ({RINGING, SNOOZED, SNOOZE_CNT, SNOOZE_TIME} !== 21'd0) begin
      failures++; $display("FAIL en_drop_idle: got ring=%b snz=%b cnt=%0d time=%h expected all 0",
                           RINGING, SNOOZED, SNOOZE_CNT, SNOOZE_TIME);
    end
    ALARM_EN = 1; tick(1);
  endtask

  task automatic test_reset_midring();
    start_ring(12, 0, 0);
    tick(30);
    checks++;
    if (BUZZER !== 1'b1) begin
      failures++; $display("FAIL midring_buzz_on: got BUZZER=%b expected 1", BUZZER);
    end
    RESETN = 0; tick(1);
    checks++;
    if (BUZZER !== 1'b0 || RINGING !== 1'b0) begin
      failures++; $display("FAIL midring_reset: got BUZZER=%b RINGING=%b expected 0 0", BUZZER, RINGING);
    end
    RESETN = 1; tick(2);
  endtask

  task automatic test_random();
    int t;
    for (int r = 0; r < 4; r++) begin
      t = int'($urandom_range(0, 86399));
      CUR_TIME = from_secs(t); tick(2);
      for (int c = 0; c < 500; c++) begin
        if (c % 150 == 0) ALARM_TIME = from_secs(t + 3);
        if ($urandom_range(0, 2) == 0) begin
          t = (t + (($urandom_range(0, 7) == 0) ? 61 : 1)) % 86400;
          CUR_TIME = from_secs(t);
        end
        STOP_BTN     = ($urandom_range(0, 79) == 0);
        SNOOZE_BTN   = ($urandom_range(0, 14) == 0);
        SETTING_BUSY = ($urandom_range(0, 29) == 0);
        ALARM_EN     = ($urandom_range(0, 199) != 0);
        tick(1);
        checks++;
        if (dut_vec !== model_vec()) begin
          failures++; $display("FAIL random r=%0d c=%0d: got %h expected %h", r, c, dut_vec, model_vec());
        end
      end
    end
    STOP_BTN = 0; SNOOZE_BTN = 0; SETTING_BUSY = 0; ALARM_EN = 1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_ring_stop();
    test_snooze();
    test_snooze_wrap_limit();
    test_timeout();
    test_stop_snooze_same();
    test_busy();
    test_en_drop_snooze();
    test_reset_midring();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
